// File: rtl/filt_pkg.sv
// Shared definitions for the filter datapath and its serial output stage.
package filt_pkg;

    // Width of filtered samples produced by filt and consumed by filt_out_ser.
    localparam int SAMPLE_W = 16;

    // Serializer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

endpackage

// File: rtl/filt_out_ser_sync_fifo.sv
// sync_fifo: single-clock circular buffer with occupancy counter.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
    end

    // Control registers; reset discards buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/filt_out_ser.sv
// filt_out_ser: buffers samples from filt and shifts them out MSB-first,
// one bit per ser_en tick, with a frame marker on the first bit of each word.
// Optional build macro FILT_OUT_OVF_CNT_EN adds a saturating dropped-sample
// counter on port ovf_cnt.
module filt_out_ser
    import filt_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         push,
    input  logic         ser_en,
    output logic         sdo,
    output logic         frame,
    output logic         busy,
    output logic         full,
    output logic         empty,
    output logic         ovf
`ifdef FILT_OUT_OVF_CNT_EN
    ,
    output logic [7:0]   ovf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(W);

    ser_state_t     state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  bitcnt_q, bitcnt_d;
    logic           ovf_q, ovf_d;
    logic           pop;
    logic           drop;
    logic [W-1:0]   fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serializer next state, shift register, bit counter and outputs.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sdo      = 1'b0;
        frame    = 1'b0;
        busy     = 1'b1;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                pop      = 1'b1;
                shreg_d  = fifo_dout;
                bitcnt_d = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                sdo   = shreg_q[W-1];
                frame = (bitcnt_q == '0);
                if (ser_en) begin
                    shreg_d  = {shreg_q[W-2:0], 1'b0};
                    bitcnt_d = bitcnt_q + CW'(1);
                    if (bitcnt_q == CW'(W-1)) state_d = fifo_empty ? IDLE : LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A push is lost only when the buffer is full and no pop frees a slot.
    assign drop = push && (fifo_count == (AW+1)'(DEPTH)) && !pop;

    // Sticky overflow flag.
    always_comb begin
        ovf_d = ovf_q | drop;
    end

    // Serializer control state; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Shift register data; output is gated by state so no reset is needed.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

`ifdef FILT_OUT_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Dropped-sample counter, saturating at 255.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    // Dropped-sample counter register.
    always_ff @(posedge clk) begin
        if (rst) ovf_cnt_q <= 8'd0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign full  = fifo_full;
    assign empty = fifo_empty;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_filt_out_ser.sv
// Directed testbench for filt_out_ser (W=16, DEPTH=8).
module tb_filt_out_ser;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        push;
    logic        ser_en;
    logic        sdo;
    logic        frame;
    logic        busy;
    logic        full;
    logic        empty;
    logic        ovf;
`ifdef FILT_OUT_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    filt_out_ser #(.W(16), .DEPTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .push   (push),
        .ser_en (ser_en),
        .sdo    (sdo),
        .frame  (frame),
        .busy   (busy),
        .full   (full),
        .empty  (empty),
        .ovf    (ovf)
`ifdef FILT_OUT_OVF_CNT_EN
        ,
        .ovf_cnt(ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs settle 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [15:0] w);
        din  = w;
        push = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called with the FSM in SHIFT on bit 0; ser_en pulses on the last
    // cycle of every 'period' cycles, so each bit is held 'period' cycles.
    task automatic expect_word(input string tag, input logic [15:0] w, input int period);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < period; k++) begin
                ser_en = (k == period - 1);
                check($sformatf("%s sdo b%0d", tag, i), 32'(sdo), 32'(w[15-i]));
                check($sformatf("%s frame b%0d", tag, i), 32'(frame), 32'(i == 0));
                tick();
            end
        end
        ser_en = 1'b0;
    endtask

    // The single LOAD cycle between consecutive words.
    task automatic expect_gap(input string tag);
        check({tag, " gap busy"}, 32'(busy), 32'd1);
        check({tag, " gap sdo"}, 32'(sdo), 32'd0);
        check({tag, " gap frame"}, 32'(frame), 32'd0);
        tick();
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle empty"}, 32'(empty), 32'd1);
        check({tag, " idle sdo"}, 32'(sdo), 32'd0);
    endtask

    initial begin
        int frames;
        rst    = 1'b1;
        din    = '0;
        push   = 1'b0;
        ser_en = 1'b0;

        // Reset values
        do_reset();
        check("rst sdo", 32'(sdo), 32'd0);
        check("rst frame", 32'(frame), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst full", 32'(full), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst ovf", 32'(ovf), 32'd0);
`ifdef FILT_OUT_OVF_CNT_EN
        check("rst ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif

        // Single word 0xA5C3 with ser_en high: empty drops, LOAD, then SHIFT
        ser_en = 1'b1;
        do_push(16'hA5C3);
        check("t1 empty after push", 32'(empty), 32'd0);
        check("t1 busy after push", 32'(busy), 32'd0);
        tick();
        check("t1 load busy", 32'(busy), 32'd1);
        check("t1 load frame", 32'(frame), 32'd0);
        tick();
        expect_word("t1", 16'b1010010111000011, 1);
        expect_idle("t1");

        // Slow bit rate: ser_en every 4th cycle
        do_push(16'h8001);
        tick();
        tick();
        expect_word("t2", 16'h8001, 4);
        expect_idle("t2");

        // Fill with ser_en low. Word 1 is moved into the shifter by LOAD,
        // so nine words are buffered before the FIFO reports full.
        do_reset();
        for (int i = 1; i <= 8; i++) do_push(16'(i));
        check("t3 full after 8", 32'(full), 32'd0);
        do_push(16'd9);
        check("t3 full after 9", 32'(full), 32'd1);
        check("t3 ovf after 9", 32'(ovf), 32'd0);
        do_push(16'd10);
        check("t3 full after 10", 32'(full), 32'd1);
        check("t3 ovf after 10", 32'(ovf), 32'd1);
`ifdef FILT_OUT_OVF_CNT_EN
        check("t3 ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
        expect_word("t3 w1", 16'd1, 1);
        for (int i = 2; i <= 9; i++) begin
            expect_gap($sformatf("t3 w%0d", i));
            expect_word($sformatf("t3 w%0d", i), 16'(i), 1);
        end
        expect_idle("t3");
        check("t3 ovf sticky", 32'(ovf), 32'd1);

        // Push into a full FIFO in the same cycle as the LOAD pop
        do_reset();
        for (int i = 1; i <= 9; i++) do_push(16'(i));
        check("t4 full", 32'(full), 32'd1);
        expect_word("t4 w1", 16'd1, 1);
        check("t4 load busy", 32'(busy), 32'd1);
        check("t4 load frame", 32'(frame), 32'd0);
        check("t4 load full", 32'(full), 32'd1);
        do_push(16'h00AA);
        check("t4 full kept", 32'(full), 32'd1);
        check("t4 ovf kept 0", 32'(ovf), 32'd0);
        expect_word("t4 w2", 16'd2, 1);
        for (int i = 3; i <= 9; i++) begin
            expect_gap($sformatf("t4 w%0d", i));
            expect_word($sformatf("t4 w%0d", i), 16'(i), 1);
        end
        expect_gap("t4 wAA");
        expect_word("t4 wAA", 16'h00AA, 1);
        expect_idle("t4");
        check("t4 ovf end", 32'(ovf), 32'd0);

        // Back-to-back words separated by one LOAD cycle
        ser_en = 1'b1;
        do_push(16'h1234);
        do_push(16'hFFFF);
        tick();
        expect_word("t5 w0", 16'h1234, 1);
        expect_gap("t5");
        expect_word("t5 w1", 16'hFFFF, 1);
        expect_idle("t5");

        // Reset mid-word aborts it and discards the buffered word
        ser_en = 1'b1;
        do_push(16'h5A5A);
        do_push(16'h0F0F);
        tick();
        for (int i = 0; i < 7; i++) tick();
        ser_en = 1'b1;
        check("t6 busy before rst", 32'(busy), 32'd1);
        check("t6 empty before rst", 32'(empty), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 sdo", 32'(sdo), 32'd0);
        check("t6 frame", 32'(frame), 32'd0);
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 empty", 32'(empty), 32'd1);
        check("t6 ovf", 32'(ovf), 32'd0);
        frames = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame || busy) frames++;
            tick();
        end
        check("t6 no activity", 32'(frames), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
